krms_stats_mc: RTL and testbench
================================

Name: krms_stats_mc

Overview:
- Multi-channel successor to the single-stream RMS square-sum front end.
- Accumulates per-channel sum of squares, and optionally the plain sum for LayerNorm mode, over K elements for CH_NUM interleaved channels (heads/tokens).
- Emits one result per channel through a valid/ready FIFO to the downstream float scale pipeline (i2flt/mult/div/invsqrt).
- Handles a K that is not a multiple of BUS_NUM, applies backpressure, and reports misuse.

Parameters:
BUS_NUM, 8, elements per input beat
DATA_WIDTH, 8, signed element width
DATA_NUM_WIDTH, 10, width of K and per-channel element counters
CH_NUM, 4, number of interleaved channels
SUM_WIDTH, 32, accumulator/output width; must be >= 2*DATA_WIDTH+DATA_NUM_WIDTH
OUT_DEPTH, 4, result FIFO depth (>=2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  pulse: begin a pass using cfg_k/cfg_mode
cfg_k  in  DATA_NUM_WIDTH  elements per channel (K)
cfg_mode  in  1  0=RMS (squares only), 1=LayerNorm (squares + sum)
in_data  in  BUS_NUM*DATA_WIDTH  signed lanes, lane 0 = LSBs
in_ch  in  max(1,$clog2(CH_NUM))  channel tag of beat
in_vld  in  1  beat valid
in_rdy  out  1  beat accepted when in_vld&&in_rdy
out_sq_sum  out  SUM_WIDTH  unsigned sum of squares
out_sum  out  SUM_WIDTH  signed sum (0 in RMS mode)
out_ch  out  max(1,$clog2(CH_NUM))  channel of result
out_vld  out  1  FIFO head valid
out_rdy  in  1  consumer ready
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at DRAIN->IDLE
err  out  1  sticky misuse flag, cleared by next accepted start

Behaviour:
- Reset: every output 0; FSM IDLE; counters, accumulators, done-mask, FIFO, pipe flags cleared. Reset mid-pass aborts the pass with no result emitted.
- FSM IDLE: on start with cfg_k!=0, latch cfg_k/cfg_mode, clear err, then RUN. On start with cfg_k==0, set err and stay IDLE.
- FSM RUN: when done-mask is all ones, go to DRAIN. start is ignored in RUN and DRAIN.
- FSM DRAIN: go to IDLE with done=1 once pipe is empty and FIFO is empty.
- in_rdy = (state==RUN) && (fifo_count + last-flags in pipe stages 1..2) < OUT_DEPTH. Combinational from registers.
- Stage 0 (accept cycle T), using per-channel count c:
  - lane i valid iff c+i < K;
  - last = (c+BUS_NUM >= K);
  - count <= last ? 0 : c+BUS_NUM;
  - done-mask[ch] set on last.
- Beat to a channel whose done bit is set, or in_ch >= CH_NUM: dropped, err set, no state change.
- Stage 1 (edge T+1): register masked squares (x*x, 2*DATA_WIDTH unsigned; -128^2=16384) and masked sign-extended x. Invalid lanes contribute 0.
- Stage 2 (edge T+2): add lane sums to channel accumulators. If last, push {sq, sum, ch} into FIFO and zero the channel accumulators. out_vld is visible in cycle T+2.
  - Same-channel back-to-back beats must accumulate correctly.
  - RMS mode: sum accumulator held at 0.
- FIFO: first-word-fall-through. Head is stable while out_vld && !out_rdy. Push and pop in the same cycle are allowed. Overflow is impossible by the credit rule.
- Channels complete in arrival order; out_ch identifies each result.
- No saturation needed given the SUM_WIDTH constraint.

Optional Feature:
- Macro KRMS_STATS_ABSMAX_EN.
- Defined: extra output out_absmax (DATA_WIDTH unsigned) with the per-channel max |x| over valid lanes (|-128|=128). It is carried in the FIFO entry and cleared with the channel on last.
- Undefined: port absent, no max logic.

Test Plan:
- BUS_NUM=8, CH_NUM=2, K=16, mode=1, all lanes 3, beats ch0,ch0,ch1,ch1 -> two results: sq=144, sum=48, out_ch 0 then 1; first out_vld 2 cycles after first last-beat accept; done pulses once after both are popped.
- K=10, ch0, beat1 all 1, beat2 lanes0-1=1 and lanes2-7=100 -> sq=10, sum=10 (mode 1); mode 0 -> sum=0.
- All lanes -128, K=8, CH_NUM=1 -> sq=131072, sum=-1024 (mode 1).
- out_rdy held 0, OUT_DEPTH=4, CH_NUM=4, K=8, one beat per channel -> in_rdy drops once credits reach 4; head holds ch0 values stable until out_rdy=1.
- Beat to completed ch0 during RUN -> dropped, err=1, other results unchanged. Start with cfg_k=0 -> err=1, busy stays 0.
- rst=1 mid-pass (ch0 half accumulated), then start and a full pass -> no stale result; all outputs 0 during reset; new results correct.

Source files
------------

// File: rtl/krms_stats_mc.sv
// rtl/krms_stats_mc.sv - multi-channel sum-of-squares / sum front end with result FIFO (option: KRMS_STATS_ABSMAX_EN)
module krms_stats_mc #(
    parameter int BUS_NUM        = 8,
    parameter int DATA_WIDTH     = 8,
    parameter int DATA_NUM_WIDTH = 10,
    parameter int CH_NUM         = 4,
    parameter int SUM_WIDTH      = 32,
    parameter int OUT_DEPTH      = 4
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       start,
    input  logic [DATA_NUM_WIDTH-1:0]                  cfg_k,
    input  logic                                       cfg_mode,
    input  logic [BUS_NUM*DATA_WIDTH-1:0]              in_data,
    input  logic [((CH_NUM > 1) ? $clog2(CH_NUM) : 1)-1:0] in_ch,
    input  logic                                       in_vld,
    output logic                                       in_rdy,
    output logic [SUM_WIDTH-1:0]                       out_sq_sum,
    output logic [SUM_WIDTH-1:0]                       out_sum,
    output logic [((CH_NUM > 1) ? $clog2(CH_NUM) : 1)-1:0] out_ch,
    output logic                                       out_vld,
    input  logic                                       out_rdy,
    output logic                                       busy,
    output logic                                       done,
`ifdef KRMS_STATS_ABSMAX_EN
    output logic [DATA_WIDTH-1:0]                      out_absmax,
`endif
    output logic                                       err
);

    localparam int CH_W  = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam int SQ_W  = 2 * DATA_WIDTH;
    localparam int CNT_W = DATA_NUM_WIDTH + $clog2(BUS_NUM) + 1;
    localparam int PTR_W = $clog2(OUT_DEPTH);
    localparam int FC_W  = $clog2(OUT_DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t                      state_q, state_d;
    logic [DATA_NUM_WIDTH-1:0]   k_q, k_d;
    logic                        mode_q, mode_d, err_q, err_d, done_q, done_d, busy_q, busy_d;
    logic [DATA_NUM_WIDTH-1:0]   cnt_q [CH_NUM];
    logic [DATA_NUM_WIDTH-1:0]   cnt_d [CH_NUM];
    logic [CH_NUM-1:0]           dmask_q, dmask_d;
    logic                        s1_vld_q, s1_vld_d, s1_last_q, s1_last_d;
    logic [CH_W-1:0]             s1_ch_q, s1_ch_d;
    logic [SQ_W-1:0]             s1_sq_q [BUS_NUM];
    logic [SQ_W-1:0]             s1_sq_d [BUS_NUM];
    logic signed [DATA_WIDTH-1:0] s1_x_q [BUS_NUM];
    logic signed [DATA_WIDTH-1:0] s1_x_d [BUS_NUM];
    logic [SUM_WIDTH-1:0]        acc_sq_q [CH_NUM];
    logic [SUM_WIDTH-1:0]        acc_sq_d [CH_NUM];
    logic [SUM_WIDTH-1:0]        acc_sum_q [CH_NUM];
    logic [SUM_WIDTH-1:0]        acc_sum_d [CH_NUM];
    logic [SUM_WIDTH-1:0]        f_sq_q [OUT_DEPTH];
    logic [SUM_WIDTH-1:0]        f_sq_d [OUT_DEPTH];
    logic [SUM_WIDTH-1:0]        f_sum_q [OUT_DEPTH];
    logic [SUM_WIDTH-1:0]        f_sum_d [OUT_DEPTH];
    logic [CH_W-1:0]             f_ch_q [OUT_DEPTH];
    logic [CH_W-1:0]             f_ch_d [OUT_DEPTH];
    logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FC_W-1:0]             fcnt_q, fcnt_d;
`ifdef KRMS_STATS_ABSMAX_EN
    logic [DATA_WIDTH-1:0]       s1_amax_q, s1_amax_d;
    logic [DATA_WIDTH-1:0]       acc_amax_q [CH_NUM];
    logic [DATA_WIDTH-1:0]       acc_amax_d [CH_NUM];
    logic [DATA_WIDTH-1:0]       f_amax_q [OUT_DEPTH];
    logic [DATA_WIDTH-1:0]       f_amax_d [OUT_DEPTH];
    logic [DATA_WIDTH-1:0]       lane_abs, new_amax;
`endif

    logic [FC_W:0]               credits;
    logic                        accept, ch_in_range, ch_ok, last, push, pop, lane_v;
    logic [CH_W-1:0]             ch_idx;
    logic [CNT_W-1:0]            c_ext, k_ext;
    logic signed [DATA_WIDTH-1:0] lane_x;
    logic signed [SQ_W-1:0]      lane_prod;
    logic [SUM_WIDTH-1:0]        sq_add, sum_add, new_sq, new_sum;

    // Results already queued plus a last beat still in the square stage each hold one FIFO slot.
    assign credits    = {1'b0, fcnt_q} + (FC_W + 1)'(s1_vld_q & s1_last_q);
    assign in_rdy     = (state_q == S_RUN) && (credits < (FC_W + 1)'(OUT_DEPTH));
    assign out_vld    = (fcnt_q != '0);
    assign out_sq_sum = f_sq_q[rd_ptr_q];
    assign out_sum    = f_sum_q[rd_ptr_q];
    assign out_ch     = f_ch_q[rd_ptr_q];
`ifdef KRMS_STATS_ABSMAX_EN
    assign out_absmax = f_amax_q[rd_ptr_q];
`endif
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

    // Next-state logic: control FSM, lane masking/squaring, channel accumulation and result FIFO.
    always_comb begin
        state_d  = state_q;   k_d      = k_q;      mode_d   = mode_q;
        err_d    = err_q;     done_d   = 1'b0;     cnt_d    = cnt_q;
        dmask_d  = dmask_q;   s1_vld_d = 1'b0;     s1_last_d = s1_last_q;
        s1_ch_d  = s1_ch_q;   s1_sq_d  = s1_sq_q;  s1_x_d   = s1_x_q;
        acc_sq_d = acc_sq_q;  acc_sum_d = acc_sum_q;
        f_sq_d   = f_sq_q;    f_sum_d  = f_sum_q;  f_ch_d   = f_ch_q;
        wr_ptr_d = wr_ptr_q;  rd_ptr_d = rd_ptr_q;
        lane_v   = 1'b0;      lane_x   = '0;       lane_prod = '0;
`ifdef KRMS_STATS_ABSMAX_EN
        s1_amax_d = '0;       acc_amax_d = acc_amax_q; f_amax_d = f_amax_q;
        lane_abs  = '0;
`endif

        // Stage 0: classify the beat against its channel's running element count.
        ch_in_range = int'(in_ch) < CH_NUM;
        ch_idx      = ch_in_range ? in_ch : '0;
        ch_ok       = ch_in_range && !dmask_q[ch_idx];
        accept      = in_vld && in_rdy;
        c_ext       = CNT_W'(cnt_q[ch_idx]);
        k_ext       = CNT_W'(k_q);
        last        = (c_ext + CNT_W'(BUS_NUM)) >= k_ext;

        if (accept && ch_ok) begin
            s1_vld_d  = 1'b1;
            s1_last_d = last;
            s1_ch_d   = in_ch;
            for (int i = 0; i < BUS_NUM; i++) begin
                lane_v    = (c_ext + CNT_W'(i)) < k_ext;
                lane_x    = $signed(in_data[i*DATA_WIDTH +: DATA_WIDTH]);
                lane_prod = lane_x * lane_x;
                s1_sq_d[i] = lane_v ? SQ_W'(lane_prod) : '0;
                s1_x_d[i]  = (lane_v && mode_q) ? lane_x : '0;
`ifdef KRMS_STATS_ABSMAX_EN
                lane_abs = lane_x[DATA_WIDTH-1] ? DATA_WIDTH'(-lane_x) : DATA_WIDTH'(lane_x);
                if (lane_v && (lane_abs > s1_amax_d)) s1_amax_d = lane_abs;
`endif
            end
            cnt_d[ch_idx] = last ? '0 : DATA_NUM_WIDTH'(c_ext + CNT_W'(BUS_NUM));
            if (last) dmask_d[ch_idx] = 1'b1;
        end else if (accept) begin
            err_d = 1'b1;
        end

        // Stage 2: fold the registered lanes into the channel and emit on its last beat.
        sq_add  = '0;
        sum_add = '0;
        for (int i = 0; i < BUS_NUM; i++) begin
            sq_add  = sq_add + SUM_WIDTH'(s1_sq_q[i]);
            sum_add = sum_add + {{(SUM_WIDTH-DATA_WIDTH){s1_x_q[i][DATA_WIDTH-1]}}, s1_x_q[i]};
        end
        new_sq  = acc_sq_q[s1_ch_q] + sq_add;
        new_sum = acc_sum_q[s1_ch_q] + sum_add;
`ifdef KRMS_STATS_ABSMAX_EN
        new_amax = (s1_amax_q > acc_amax_q[s1_ch_q]) ? s1_amax_q : acc_amax_q[s1_ch_q];
`endif
        push = s1_vld_q && s1_last_q;
        pop  = out_rdy && (fcnt_q != '0);

        if (s1_vld_q) begin
            acc_sq_d[s1_ch_q]  = s1_last_q ? '0 : new_sq;
            acc_sum_d[s1_ch_q] = s1_last_q ? '0 : new_sum;
`ifdef KRMS_STATS_ABSMAX_EN
            acc_amax_d[s1_ch_q] = s1_last_q ? '0 : new_amax;
`endif
        end
        if (push) begin
            f_sq_d[wr_ptr_q]  = new_sq;
            f_sum_d[wr_ptr_q] = new_sum;
            f_ch_d[wr_ptr_q]  = s1_ch_q;
`ifdef KRMS_STATS_ABSMAX_EN
            f_amax_d[wr_ptr_q] = new_amax;
`endif
            wr_ptr_d = (wr_ptr_q == PTR_W'(OUT_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = (rd_ptr_q == PTR_W'(OUT_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        fcnt_d = fcnt_q + FC_W'(push) - FC_W'(pop);

        // Control FSM; start is only honoured while idle.
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (cfg_k != '0) begin
                        k_d     = cfg_k;
                        mode_d  = cfg_mode;
                        err_d   = 1'b0;
                        dmask_d = '0;
                        for (int c = 0; c < CH_NUM; c++) cnt_d[c] = '0;
                        state_d = S_RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_RUN:   if (&dmask_q) state_d = S_DRAIN;
            S_DRAIN: begin
                if (!s1_vld_q && (fcnt_q == '0)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State registers with synchronous reset; reset discards any pass in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE; k_q <= '0; mode_q <= 1'b0; err_q <= 1'b0;
            done_q   <= 1'b0;   busy_q <= 1'b0; dmask_q <= '0;
            s1_vld_q <= 1'b0;   s1_last_q <= 1'b0; s1_ch_q <= '0;
            wr_ptr_q <= '0;     rd_ptr_q <= '0; fcnt_q <= '0;
            for (int c = 0; c < CH_NUM; c++) begin
                cnt_q[c] <= '0; acc_sq_q[c] <= '0; acc_sum_q[c] <= '0;
`ifdef KRMS_STATS_ABSMAX_EN
                acc_amax_q[c] <= '0;
`endif
            end
            for (int i = 0; i < BUS_NUM; i++) begin
                s1_sq_q[i] <= '0; s1_x_q[i] <= '0;
            end
            for (int e = 0; e < OUT_DEPTH; e++) begin
                f_sq_q[e] <= '0; f_sum_q[e] <= '0; f_ch_q[e] <= '0;
`ifdef KRMS_STATS_ABSMAX_EN
                f_amax_q[e] <= '0;
`endif
            end
`ifdef KRMS_STATS_ABSMAX_EN
            s1_amax_q <= '0;
`endif
        end else begin
            state_q  <= state_d;  k_q <= k_d; mode_q <= mode_d; err_q <= err_d;
            done_q   <= done_d;   busy_q <= busy_d; dmask_q <= dmask_d; cnt_q <= cnt_d;
            s1_vld_q <= s1_vld_d; s1_last_q <= s1_last_d; s1_ch_q <= s1_ch_d;
            s1_sq_q  <= s1_sq_d;  s1_x_q <= s1_x_d;
            acc_sq_q <= acc_sq_d; acc_sum_q <= acc_sum_d;
            f_sq_q   <= f_sq_d;   f_sum_q <= f_sum_d; f_ch_q <= f_ch_d;
            wr_ptr_q <= wr_ptr_d; rd_ptr_q <= rd_ptr_d; fcnt_q <= fcnt_d;
`ifdef KRMS_STATS_ABSMAX_EN
            s1_amax_q <= s1_amax_d; acc_amax_q <= acc_amax_d; f_amax_q <= f_amax_d;
`endif
        end
    end

endmodule

// File: tb/tb_krms_stats_mc.sv
// tb/tb_krms_stats_mc.sv - directed table-driven bench for krms_stats_mc
module tb_krms_stats_mc;

    localparam int DNW = 10;

    logic        clk = 1'b0;
    logic        rst, start, cfg_mode, in_vld, out_rdy;
    logic [DNW-1:0] cfg_k;
    logic [63:0] in_data;
    logic [1:0]  in_ch, out_ch;
    logic        in_rdy, out_vld, busy, done, err;
    logic [31:0] out_sq_sum, out_sum;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        int k;
        bit mode;
        int v;
        int tail;
        int exp_sq;
        int exp_sum;
    } vec_t;
    vec_t vecs [8];

    always #5 clk = ~clk;

    krms_stats_mc #(
        .BUS_NUM(8), .DATA_WIDTH(8), .DATA_NUM_WIDTH(DNW),
        .CH_NUM(4), .SUM_WIDTH(32), .OUT_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_k(cfg_k), .cfg_mode(cfg_mode),
        .in_data(in_data), .in_ch(in_ch), .in_vld(in_vld), .in_rdy(in_rdy),
        .out_sq_sum(out_sq_sum), .out_sum(out_sum), .out_ch(out_ch),
        .out_vld(out_vld), .out_rdy(out_rdy), .busy(busy), .done(done), .err(err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] beat_data(input int k, input int b, input int v, input int tail);
        logic [63:0] d;
        d = '0;
        for (int i = 0; i < 8; i++) d[i*8 +: 8] = ((b * 8 + i) < k) ? 8'(v) : 8'(tail);
        return d;
    endfunction

    function automatic logic [63:0] fill(input int v);
        logic [63:0] d;
        for (int i = 0; i < 8; i++) d[i*8 +: 8] = 8'(v);
        return d;
    endfunction

    task automatic do_start(input int k, input bit mode);
        cfg_k = DNW'(k); cfg_mode = mode; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_beat(input int ch, input logic [63:0] d);
        bit ok;
        ok = 1'b0;
        in_vld = 1'b1; in_ch = 2'(ch); in_data = d;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            if (in_rdy) ok = 1'b1;
            tick();
        end
        in_vld = 1'b0;
        chk("beat_accepted", 32'(ok), 32'd1);
    endtask

    task automatic collect(input int ch, input int sq, input int sum);
        bit found;
        found = 1'b0;
        out_rdy = 1'b1;
        for (int n = 0; n < 30 && !found; n++) begin
            @(negedge clk);
            if (out_vld) begin
                found = 1'b1;
                chk("res_ch", 32'(out_ch), 32'(ch));
                chk("res_sq", out_sq_sum, sq);
                chk("res_sum", out_sum, sum);
            end
            tick();
        end
        out_rdy = 1'b0;
        chk("res_seen", 32'(found), 32'd1);
    endtask

    task automatic check_done();
        int pulses;
        pulses = 0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (done) pulses++;
            tick();
        end
        chk("done_pulses", pulses, 1);
        chk("busy_after_done", 32'(busy), 32'd0);
    endtask

    task automatic run_pass(input vec_t t);
        int nb;
        nb = (t.k + 7) / 8;
        do_start(t.k, t.mode);
        for (int ch = 0; ch < 4; ch++)
            for (int b = 0; b < nb; b++) send_beat(ch, beat_data(t.k, b, t.v, t.tail));
        for (int ch = 0; ch < 4; ch++) collect(ch, t.exp_sq, t.exp_sum);
        check_done();
    endtask

    task automatic check_all_zero();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_in_rdy", 32'(in_rdy), 32'd0);
        chk("rst_out_vld", 32'(out_vld), 32'd0);
        chk("rst_out_sq", out_sq_sum, 32'd0);
        chk("rst_out_sum", out_sum, 32'd0);
        chk("rst_out_ch", 32'(out_ch), 32'd0);
    endtask

    initial begin
        vecs[0] = '{16, 1'b1,    3,   0,    144,    48};
        vecs[1] = '{10, 1'b1,    1, 100,     10,    10};
        vecs[2] = '{10, 1'b0,    1, 100,     10,     0};
        vecs[3] = '{ 8, 1'b1, -128,   0, 131072, -1024};
        vecs[4] = '{ 8, 1'b0, -128,   0, 131072,     0};
        vecs[5] = '{ 3, 1'b1,   -5, 127,     75,   -15};
        vecs[6] = '{ 1, 1'b1,    7,  -1,     49,     7};
        vecs[7] = '{20, 1'b1,    2,   9,     80,    40};

        rst = 1'b1; start = 1'b0; cfg_k = '0; cfg_mode = 1'b0;
        in_data = '0; in_ch = '0; in_vld = 1'b0; out_rdy = 1'b0;
        tick(); tick();
        @(negedge clk);
        check_all_zero();
        tick();
        rst = 1'b0;
        tick();

        // start with K=0 is misuse: err set, machine stays idle
        do_start(0, 1'b1);
        @(negedge clk);
        chk("k0_err", 32'(err), 32'd1);
        chk("k0_busy", 32'(busy), 32'd0);
        tick();

        // latency: result visible two cycles after the last beat is accepted
        do_start(16, 1'b1);
        @(negedge clk);
        chk("start_clears_err", 32'(err), 32'd0);
        chk("start_busy", 32'(busy), 32'd1);
        tick();
        send_beat(0, fill(3));
        send_beat(0, fill(3));
        @(negedge clk);
        chk("lat_t1_vld", 32'(out_vld), 32'd0);
        tick();
        @(negedge clk);
        chk("lat_t2_vld", 32'(out_vld), 32'd1);
        chk("lat_t2_ch", 32'(out_ch), 32'd0);
        chk("lat_t2_sq", out_sq_sum, 32'd144);
        tick();
        for (int ch = 1; ch < 4; ch++) begin
            send_beat(ch, fill(3));
            send_beat(ch, fill(3));
        end
        for (int ch = 0; ch < 4; ch++) collect(ch, 144, 48);
        check_done();

        for (int v = 0; v < 8; v++) run_pass(vecs[v]);

        // backpressure: four results fill the FIFO, head holds until popped
        do_start(8, 1'b1);
        for (int ch = 0; ch < 4; ch++) send_beat(ch, fill(ch + 1));
        tick();
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            chk("bp_in_rdy", 32'(in_rdy), 32'd0);
            chk("bp_head_vld", 32'(out_vld), 32'd1);
            chk("bp_head_ch", 32'(out_ch), 32'd0);
            chk("bp_head_sq", out_sq_sum, 32'd8);
            chk("bp_busy", 32'(busy), 32'd1);
            tick();
        end
        collect(0, 8, 8);
        collect(1, 32, 16);
        collect(2, 72, 24);
        collect(3, 128, 32);
        check_done();

        // beat to an already completed channel is dropped and flagged
        do_start(8, 1'b1);
        @(negedge clk);
        chk("drop_err_before", 32'(err), 32'd0);
        tick();
        send_beat(0, fill(1));
        send_beat(0, fill(50));
        @(negedge clk);
        chk("drop_err", 32'(err), 32'd1);
        tick();
        for (int ch = 1; ch < 4; ch++) send_beat(ch, fill(1));
        for (int ch = 0; ch < 4; ch++) collect(ch, 8, 8);
        check_done();
        chk("drop_err_sticky", 32'(err), 32'd1);

        // reset in the middle of a pass leaves nothing behind
        do_start(16, 1'b1);
        send_beat(0, fill(5));
        rst = 1'b1;
        tick();
        @(negedge clk);
        check_all_zero();
        tick();
        rst = 1'b0;
        tick();
        run_pass(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
